// File: rtl/quantizer_pkg.sv
// quantizer_pkg
// Shared constants for the forward quantizer: data widths, block geometry,
// rounding shift, the Annex K quantization tables and the reciprocal helper
// used to build the ROM contents at elaboration time.
package quantizer_pkg;

    localparam int Q_BIT      = 32;
    localparam int Q_FRAC     = 16;
    localparam int HDATA_BIT  = 12;
    localparam int BLOCK_BIT  = 3;
    localparam int R_BIT      = 16;

    localparam int BLOCK_AREA  = 64;
    localparam int IDX_BIT     = 2 * BLOCK_BIT;
    localparam int CNT_BIT     = 7;

    // Reciprocals are scaled by 2^RECIP_SHIFT, and the coefficient carries
    // Q_FRAC fractional bits, so the product must be shifted by both.
    localparam int RECIP_SHIFT = 16;
    localparam int ROUND_SHIFT = RECIP_SHIFT + Q_FRAC;
    localparam int PROD_BIT    = Q_BIT + R_BIT + 1;

    typedef enum logic {
        TABLE_LUMA   = 1'b0,
        TABLE_CHROMA = 1'b1
    } table_sel_e;

    localparam int unsigned LUMA_Q [BLOCK_AREA] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam int unsigned CHROMA_Q [BLOCK_AREA] = '{
        17,  18,  24,  47,  99,  99,  99,  99,
        18,  21,  26,  66,  99,  99,  99,  99,
        24,  26,  56,  99,  99,  99,  99,  99,
        47,  66,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99
    };

    // round(2^16 / q); no table entry produces an exact tie.
    function automatic logic [R_BIT-1:0] recip_of(input int unsigned q);
        return R_BIT'(((32'd1 << RECIP_SHIFT) + q / 2) / q);
    endfunction

endpackage

// File: rtl/quantizer_nicem_tersi_rom.sv
// quantizer_nicem_tersi_rom
// Combinational reciprocal ROM, 2 x 64 entries of R_BIT bits.
// Ports:
//   sec   - table select (0 luma, 1 chroma)
//   idx   - {row, col} position inside the 8x8 block
//   recip - round(65536 / Q) for the selected table entry
module quantizer_nicem_tersi_rom
    import quantizer_pkg::*;
(
    input  logic               sec,
    input  logic [IDX_BIT-1:0] idx,
    output logic [R_BIT-1:0]   recip
);

    logic [R_BIT-1:0] table_mem [2*BLOCK_AREA];

    // Contents are folded to constants at elaboration; no divider is built.
    for (genvar i = 0; i < BLOCK_AREA; i++) begin : g_entry
        localparam logic [R_BIT-1:0] LUMA_R   = recip_of(LUMA_Q[i]);
        localparam logic [R_BIT-1:0] CHROMA_R = recip_of(CHROMA_Q[i]);
        assign table_mem[i]              = LUMA_R;
        assign table_mem[BLOCK_AREA + i] = CHROMA_R;
    end

    assign recip = table_mem[{sec, idx}];

endmodule

// File: rtl/quantizer.sv
// quantizer
// Forward JPEG quantizer: coefficient * reciprocal, round half away from
// zero, symmetric saturation. Three-stage pipeline that advances as a whole.
// Ports:
//   clk_i, rst_i                      - clock, synchronous active-high reset
//   dct_veri_i / _row_i / _col_i      - signed Q16.16 coefficient and position
//   dct_tablo_sec_i                   - 0 luma, 1 chroma (sampled per block)
//   dct_veri_gecerli_i / dct_blok_son_i / dct_veri_hazir_o - input handshake
//   zig_veri_o / _row_o / _col_o      - quantized coefficient and position
//   zig_veri_gecerli_o / zig_blok_son_o / zig_veri_hazir_i - output handshake
//   blok_hata_o                       - sticky block-length error
module quantizer
    import quantizer_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [Q_BIT-1:0]     dct_veri_i,
    input  logic [BLOCK_BIT-1:0]        dct_veri_row_i,
    input  logic [BLOCK_BIT-1:0]        dct_veri_col_i,
    input  logic                        dct_tablo_sec_i,
    input  logic                        dct_veri_gecerli_i,
    input  logic                        dct_blok_son_i,
    output logic                        dct_veri_hazir_o,
    output logic signed [HDATA_BIT-1:0] zig_veri_o,
    output logic [BLOCK_BIT-1:0]        zig_veri_row_o,
    output logic [BLOCK_BIT-1:0]        zig_veri_col_o,
    output logic                        zig_veri_gecerli_o,
    output logic                        zig_blok_son_o,
    input  logic                        zig_veri_hazir_i,
    output logic                        blok_hata_o
);

    localparam logic [CNT_BIT-1:0]   LAST_CNT    = CNT_BIT'(BLOCK_AREA - 1);
    localparam logic [PROD_BIT-1:0]  ROUND_HALF  = PROD_BIT'(1) << (ROUND_SHIFT - 1);
    localparam logic [HDATA_BIT-1:0] SAT_MAX     = HDATA_BIT'((1 << (HDATA_BIT - 1)) - 1);
    localparam logic [PROD_BIT-1:0]  SAT_MAX_EXT = PROD_BIT'(SAT_MAX);

    logic                en;
    logic                accept;
    logic [CNT_BIT-1:0]  coef_cnt;
    table_sel_e          table_sel_q;
    table_sel_e          table_sel_now;
    logic [R_BIT-1:0]    rom_recip;

    logic                       s1_valid;
    logic                       s1_last;
    logic signed [Q_BIT-1:0]    s1_coef;
    logic [R_BIT-1:0]           s1_recip;
    logic [BLOCK_BIT-1:0]       s1_row;
    logic [BLOCK_BIT-1:0]       s1_col;

    logic                       s2_valid;
    logic                       s2_last;
    logic signed [PROD_BIT-1:0] s2_prod;
    logic [BLOCK_BIT-1:0]       s2_row;
    logic [BLOCK_BIT-1:0]       s2_col;

    logic signed [PROD_BIT-1:0] coef_ext;
    logic signed [PROD_BIT-1:0] recip_ext;
    logic signed [PROD_BIT-1:0] product;
    logic [PROD_BIT-1:0]        prod_mag;
    logic [PROD_BIT-1:0]        rounded;
    logic [HDATA_BIT-1:0]       mag_sat;
    logic signed [HDATA_BIT-1:0] s3_value;

    // One enable for the whole pipe: a stalled output freezes every stage,
    // so ready never depends on input valid.
    assign en               = !zig_veri_gecerli_o || zig_veri_hazir_i;
    assign dct_veri_hazir_o = en;
    assign accept           = dct_veri_gecerli_i && en;

    // The first coefficient of a block uses the live select; the rest use
    // the value latched with it.
    assign table_sel_now = (coef_cnt == '0) ? table_sel_e'(dct_tablo_sec_i) : table_sel_q;

    quantizer_nicem_tersi_rom u_rom (
        .sec   (table_sel_now),
        .idx   ({dct_veri_row_i, dct_veri_col_i}),
        .recip (rom_recip)
    );

    // Block bookkeeping: counter, per-block table select, sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_cnt    <= '0;
            table_sel_q <= TABLE_LUMA;
            blok_hata_o <= 1'b0;
        end else if (accept) begin
            if (coef_cnt == '0) begin
                table_sel_q <= table_sel_now;
            end
            if (dct_blok_son_i) begin
                if (coef_cnt != LAST_CNT) begin
                    blok_hata_o <= 1'b1;
                end
                coef_cnt <= '0;
            end else if (coef_cnt == LAST_CNT) begin
                blok_hata_o <= 1'b1;
                coef_cnt    <= '0;
            end else begin
                coef_cnt <= coef_cnt + 1'b1;
            end
        end
    end

    // Signed multiply with the reciprocal treated as a non-negative value.
    always_comb begin
        coef_ext  = {{(PROD_BIT - Q_BIT){s1_coef[Q_BIT-1]}}, s1_coef};
        recip_ext = {{(PROD_BIT - R_BIT){1'b0}}, s1_recip};
        product   = coef_ext * recip_ext;
    end

    // Round on the magnitude so halves move away from zero, clamp to the
    // symmetric range, then restore the sign (negating 0 stays 0).
    always_comb begin
        prod_mag = s2_prod;
        if (s2_prod[PROD_BIT-1]) begin
            prod_mag = -s2_prod;
        end
        rounded = (prod_mag + ROUND_HALF) >> ROUND_SHIFT;
        mag_sat = rounded[HDATA_BIT-1:0];
        if (rounded > SAT_MAX_EXT) begin
            mag_sat = SAT_MAX;
        end
        s3_value = mag_sat;
        if (s2_prod[PROD_BIT-1]) begin
            s3_value = -mag_sat;
        end
    end

    // Pipeline registers: accept, multiply, round/saturate into the outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid           <= 1'b0;
            s1_last            <= 1'b0;
            s1_coef            <= '0;
            s1_recip           <= '0;
            s1_row             <= '0;
            s1_col             <= '0;
            s2_valid           <= 1'b0;
            s2_last            <= 1'b0;
            s2_prod            <= '0;
            s2_row             <= '0;
            s2_col             <= '0;
            zig_veri_gecerli_o <= 1'b0;
            zig_blok_son_o     <= 1'b0;
            zig_veri_o         <= '0;
            zig_veri_row_o     <= '0;
            zig_veri_col_o     <= '0;
        end else if (en) begin
            s1_valid           <= dct_veri_gecerli_i;
            s1_last            <= dct_veri_gecerli_i && dct_blok_son_i;
            s1_coef            <= dct_veri_i;
            s1_recip           <= rom_recip;
            s1_row             <= dct_veri_row_i;
            s1_col             <= dct_veri_col_i;
            s2_valid           <= s1_valid;
            s2_last            <= s1_valid && s1_last;
            s2_prod            <= product;
            s2_row             <= s1_row;
            s2_col             <= s1_col;
            zig_veri_gecerli_o <= s2_valid;
            zig_blok_son_o     <= s2_valid && s2_last;
            zig_veri_o         <= s3_value;
            zig_veri_row_o     <= s2_row;
            zig_veri_col_o     <= s2_col;
        end
    end

endmodule

// File: tb/tb_quantizer.sv
// tb_quantizer
// Scoreboard bench for the forward quantizer: expected beats are queued on
// input handshakes and compared against every output handshake.
module tb_quantizer;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic signed [31:0] dct_veri_i;
    logic [2:0]         dct_veri_row_i;
    logic [2:0]         dct_veri_col_i;
    logic               dct_tablo_sec_i;
    logic               dct_veri_gecerli_i;
    logic               dct_blok_son_i;
    logic               dct_veri_hazir_o;
    logic signed [11:0] zig_veri_o;
    logic [2:0]         zig_veri_row_o;
    logic [2:0]         zig_veri_col_o;
    logic               zig_veri_gecerli_o;
    logic               zig_blok_son_o;
    logic               zig_veri_hazir_i;
    logic               blok_hata_o;

    typedef struct packed {
        logic        last;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [11:0] data;
    } beat_t;

    beat_t sbQueue[$];
    int    testCount = 0;
    int    failCount = 0;
    int    outCount  = 0;
    int    readyMode = 0;
    bit    monitorOn = 1'b0;
    int    modelCnt  = 0;
    bit    modelSel  = 1'b0;
    bit    modelHata = 1'b0;
    bit    prevValid = 1'b0;
    bit    prevReady = 1'b0;
    bit    prevRst   = 1'b1;
    beat_t prevBeat  = '0;

    int lumaQ [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
    };
    int chromaQ [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99
    };

    quantizer dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .dct_veri_i         (dct_veri_i),
        .dct_veri_row_i     (dct_veri_row_i),
        .dct_veri_col_i     (dct_veri_col_i),
        .dct_tablo_sec_i    (dct_tablo_sec_i),
        .dct_veri_gecerli_i (dct_veri_gecerli_i),
        .dct_blok_son_i     (dct_blok_son_i),
        .dct_veri_hazir_o   (dct_veri_hazir_o),
        .zig_veri_o         (zig_veri_o),
        .zig_veri_row_o     (zig_veri_row_o),
        .zig_veri_col_o     (zig_veri_col_o),
        .zig_veri_gecerli_o (zig_veri_gecerli_o),
        .zig_blok_son_o     (zig_blok_son_o),
        .zig_veri_hazir_i   (zig_veri_hazir_i),
        .blok_hata_o        (blok_hata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, actual, actual, expected, expected, $time);
        end
    endtask

    // Reference quantizer: reciprocal rounding, then half-away-from-zero.
    function automatic int quantModel(input logic signed [31:0] coef, input bit chroma, input int idx);
        longint q, r, p, mag;
        q = chroma ? chromaQ[idx] : lumaQ[idx];
        r = (65536 + q / 2) / q;
        p = longint'(coef) * r;
        mag = ((p < 0) ? -p : p) + 64'sd2147483648;
        mag = mag >>> 32;
        if (mag > 2047) mag = 2047;
        return int'((p < 0) ? -mag : mag);
    endfunction

    function automatic logic signed [31:0] randCoef();
        int raw;
        raw = $urandom;
        return raw >>> $urandom_range(2, 14);
    endfunction

    // Downstream ready: 0 always high, 1 random, 2 held low.
    initial begin
        zig_veri_hazir_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                0:       zig_veri_hazir_i = 1'b1;
                1:       zig_veri_hazir_i = 1'($urandom_range(0, 1));
                default: zig_veri_hazir_i = 1'b0;
            endcase
        end
    end

    // Monitor at the falling edge: error flag, hold stability, scoreboard.
    always @(negedge clk_i) begin
        beat_t nowBeat;
        beat_t expBeat;
        int    idx;
        bit    effSel;
        nowBeat = {zig_blok_son_o, zig_veri_row_o, zig_veri_col_o, zig_veri_o};
        if (monitorOn) begin
            checkOutput("blok_hata", int'(blok_hata_o), int'(modelHata));
            if (!zig_veri_gecerli_o) checkOutput("blok_son_no_valid", int'(zig_blok_son_o), 0);
            if (prevValid && !prevReady && !prevRst) begin
                checkOutput("hold_valid", int'(zig_veri_gecerli_o), 1);
                checkOutput("hold_beat", int'(nowBeat), int'(prevBeat));
            end
            if (zig_veri_gecerli_o && zig_veri_hazir_i && !rst_i) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_out", int'(nowBeat), -1);
                end else begin
                    expBeat = sbQueue.pop_front();
                    checkOutput("out_beat", int'(nowBeat), int'(expBeat));
                    outCount++;
                end
            end
            if (rst_i) begin
                sbQueue.delete();
                modelCnt  = 0;
                modelSel  = 1'b0;
                modelHata = 1'b0;
            end else if (dct_veri_gecerli_i && dct_veri_hazir_o) begin
                idx    = {26'd0, dct_veri_row_i, dct_veri_col_i};
                effSel = (modelCnt == 0) ? dct_tablo_sec_i : modelSel;
                if (modelCnt == 0) modelSel = dct_tablo_sec_i;
                expBeat.last = dct_blok_son_i;
                expBeat.row  = dct_veri_row_i;
                expBeat.col  = dct_veri_col_i;
                expBeat.data = 12'(quantModel(dct_veri_i, effSel, idx));
                sbQueue.push_back(expBeat);
                if (dct_blok_son_i) begin
                    if (modelCnt != 63) modelHata = 1'b1;
                    modelCnt = 0;
                end else if (modelCnt == 63) begin
                    modelHata = 1'b1;
                    modelCnt  = 0;
                end else begin
                    modelCnt++;
                end
            end
        end
        prevValid = zig_veri_gecerli_o;
        prevReady = zig_veri_hazir_i;
        prevRst   = rst_i;
        prevBeat  = nowBeat;
    end

    // Entered and left just after a rising edge; returns once accepted.
    task automatic applyStimulus(input logic signed [31:0] coef, input int idx, input bit sec, input bit last);
        int waitCycles;
        dct_veri_i         = coef;
        dct_veri_row_i     = 3'(idx / 8);
        dct_veri_col_i     = 3'(idx % 8);
        dct_tablo_sec_i    = sec;
        dct_blok_son_i     = last;
        dct_veri_gecerli_i = 1'b1;
        waitCycles = 0;
        @(negedge clk_i);
        while (!dct_veri_hazir_o && waitCycles < 200) begin
            @(negedge clk_i);
            waitCycles++;
        end
        if (!dct_veri_hazir_o) checkOutput("accept_timeout", int'(dct_veri_hazir_o), 1);
        @(posedge clk_i);
        #1;
        dct_veri_gecerli_i = 1'b0;
        dct_blok_son_i     = 1'b0;
    endtask

    task automatic drainQueue();
        int n;
        n = 0;
        while (sbQueue.size() != 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (sbQueue.size() != 0) checkOutput("drain_timeout", sbQueue.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic directedBeat(input string tag, input logic signed [31:0] coef, input int idx,
                                input int expected, input bit checkLatency);
        int waitCycles;
        waitCycles = 0;
        applyStimulus(coef, idx, 1'b0, 1'b0);
        if (checkLatency) begin
            @(negedge clk_i);
            checkOutput("latency_c1", int'(zig_veri_gecerli_o), 0);
            @(negedge clk_i);
            checkOutput("latency_c2", int'(zig_veri_gecerli_o), 0);
            @(negedge clk_i);
            checkOutput("latency_c3", int'(zig_veri_gecerli_o), 1);
        end else begin
            @(negedge clk_i);
            while (!zig_veri_gecerli_o && waitCycles < 20) begin
                @(negedge clk_i);
                waitCycles++;
            end
            checkOutput({tag, "_valid"}, int'(zig_veri_gecerli_o), 1);
        end
        checkOutput(tag, int'(zig_veri_o), expected);
        checkOutput({tag, "_row"}, int'(zig_veri_row_o), idx / 8);
        checkOutput({tag, "_col"}, int'(zig_veri_col_o), idx % 8);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int startCount;
        rst_i              = 1'b1;
        dct_veri_i         = '0;
        dct_veri_row_i     = '0;
        dct_veri_col_i     = '0;
        dct_tablo_sec_i    = 1'b0;
        dct_veri_gecerli_i = 1'b0;
        dct_blok_son_i     = 1'b0;
        readyMode          = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_valid", int'(zig_veri_gecerli_o), 0);
        checkOutput("rst_data", int'(zig_veri_o), 0);
        checkOutput("rst_row", int'(zig_veri_row_o), 0);
        checkOutput("rst_col", int'(zig_veri_col_o), 0);
        checkOutput("rst_last", int'(zig_blok_son_o), 0);
        checkOutput("rst_hata", int'(blok_hata_o), 0);
        checkOutput("rst_ready", int'(dct_veri_hazir_o), 1);
        monitorOn = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] directed coefficients");
        directedBeat("q_100", 32'sh0064_0000, 0, 6, 1'b1);
        directedBeat("q_m24", -(32'sd24 <<< 16), 0, -2, 1'b0);
        directedBeat("q_55", 32'sd55 <<< 16, 1, 5, 1'b0);
        directedBeat("q_sat_pos", 32'sd32000 <<< 16, 2, 2047, 1'b0);
        directedBeat("q_sat_neg", -(32'sd32000 <<< 16), 2, -2047, 1'b0);
        drainQueue();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        $display("[TB] full luma block with random ready");
        startCount = outCount;
        readyMode  = 1;
        for (int i = 0; i < 64; i++) begin
            if (i == 30) begin
                readyMode = 0;
                drainQueue();
                readyMode = 2;
                fork
                    begin
                        repeat (12) @(posedge clk_i);
                        readyMode = 1;
                    end
                join_none
            end
            applyStimulus(randCoef(), i, 1'b0, i == 63);
        end
        drainQueue();
        checkOutput("stream_count", outCount - startCount, 64);
        checkOutput("stream_hata", int'(blok_hata_o), 0);

        $display("[TB] short block");
        readyMode = 0;
        for (int i = 0; i < 10; i++) applyStimulus(randCoef(), i, 1'b0, i == 9);
        drainQueue();
        checkOutput("short_hata", int'(blok_hata_o), 1);

        $display("[TB] chroma block with toggling select");
        for (int i = 0; i < 64; i++) applyStimulus(randCoef(), i, (i == 0) ? 1'b1 : 1'(i % 2), i == 63);
        drainQueue();
        checkOutput("chroma_hata_sticky", int'(blok_hata_o), 1);

        $display("[TB] reset with beats in flight");
        readyMode = 2;
        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(32'sh0064_0000, i, 1'b0, 1'b0);
        checkOutput("flight_full", int'(zig_veri_gecerli_o), 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("flight_rst_valid", int'(zig_veri_gecerli_o), 0);
        checkOutput("flight_rst_data", int'(zig_veri_o), 0);
        checkOutput("flight_rst_hata", int'(blok_hata_o), 0);
        readyMode = 0;
        repeat (12) @(negedge clk_i);
        checkOutput("flight_queue", sbQueue.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
